// File: rtl/my_seq_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB slice first,
// and presents a registered sum/cout/ovf with a one-cycle done pulse.

module my_seq_adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] s_o,
  output logic         co_o,
  output logic         cmsb_o
);
  logic [W:0] t;

  assign t      = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, ci_i};
  assign s_o    = t[W-1:0];
  assign co_o   = t[W];
  // Carry into the slice MSB, recovered from the MSB sum bit.
  assign cmsb_o = t[W-1] ^ a_i[W-1] ^ b_i[W-1];
endmodule

module my_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_co, sl_cmsb;
  int               base;

  assign base  = int'(idx_q) * CHUNK;
  assign b_eff = sub_q ? ~b_q : b_q;
  assign sl_a  = a_q[base +: CHUNK];
  assign sl_b  = b_eff[base +: CHUNK];

  my_seq_adder_chunk #(.W(CHUNK)) u_chunk (
    .a_i    (sl_a),
    .b_i    (sl_b),
    .ci_i   (carry_q),
    .s_o    (sl_s),
    .co_o   (sl_co),
    .cmsb_o (sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub | cin;
          idx_d   = '0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // Slices collect in acc; sum only changes when the last slice lands.
        acc_d[base +: CHUNK] = sl_s;
        carry_d = sl_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = sl_co;
          ovf_d   = sl_co ^ sl_cmsb;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);
endmodule

// File: doc/my_seq_adder.md
MY_SEQ_ADDER -- requirements
Module: my_seq_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL derive NCHUNK = WIDTH/CHUNK internally; counter width = ceil(log2(NCHUNK)), minimum 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to begin an operation.
REQ-007 SHALL have port sub, input, 1, mode select: 0 = add, 1 = subtract.
REQ-008 SHALL have port cin, input, 1, carry-in for add mode; ignored when sub=1.
REQ-009 SHALL have port a, input, WIDTH, operand A.
REQ-010 SHALL have port b, input, WIDTH, operand B.
REQ-011 SHALL have port sum, output, WIDTH, registered result.
REQ-012 SHALL have port cout, output, 1, registered carry out of the MSB.
REQ-013 SHALL have port ovf, output, 1, registered two's-complement signed overflow.
REQ-014 SHALL have port busy, output, 1, high while chunks are being processed.
REQ-015 SHALL have port done, output, 1, one-cycle pulse marking result valid.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE; busy=1 only in BUSY; done=1 only in DONE.
REQ-017 SHALL accept start on a rising edge when state is IDLE or DONE; on acceptance, latch a, b, sub and the effective carry (sub ? 1 : cin), clear the chunk index, and go to BUSY.
REQ-018 SHALL ignore start while in BUSY; the latched operands SHALL not change.
REQ-019 SHALL, in BUSY, process one CHUNK-bit slice per edge, LSB slice first: slice(a) + slice(sub ? ~b : b) + carry register; store the slice result; update the carry register with the slice carry-out.
REQ-020 SHALL, on the edge processing slice NCHUNK-1, load sum, cout and ovf, and go to DONE.
REQ-021 SHALL compute ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 SHALL set cout in subtract mode to the raw carry of a + ~b + 1 (1 = no borrow).
REQ-023 SHALL assert done NCHUNK cycles after the start-accept edge, for exactly one cycle.
REQ-024 SHALL go from DONE to IDLE on the next edge unless start is high, in which case REQ-017 applies (back-to-back).
REQ-025 SHALL hold sum, cout and ovf stable from DONE until the next completion or reset; intermediate slices SHALL NOT appear on sum.
REQ-026 SHALL produce identical results for any legal CHUNK (CHUNK=WIDTH gives single-cycle latency: NCHUNK=1).
REQ-027 SHALL use modulo-2^WIDTH arithmetic; no saturation.

Reset
REQ-028 SHALL, on any edge with rst=1, enter IDLE and clear sum, cout, ovf, busy, done, the chunk index, the carry register and the latched operands to 0, regardless of state.
REQ-029 SHALL give rst priority over start; a reset mid-operation SHALL abort it with no done pulse.
REQ-030 SHALL honour start on the first edge after rst deasserts.

Verification (WIDTH=16, CHUNK=4)
REQ-031 SHALL cover: a=0x1234, b=0x0001, cin=0, sub=0 -> sum=0x1235, cout=0, ovf=0, done 4 cycles after the accept edge, busy high for 4 cycles.
REQ-032 SHALL cover: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 SHALL cover: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0; and a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 SHALL cover: start pulsed again in BUSY with different operands -> ignored; the result matches the first operands.
REQ-035 SHALL cover: rst asserted on the 2nd BUSY cycle -> next cycle IDLE, all outputs 0, no done; a fresh start then completes normally.
REQ-036 SHALL cover: start held high during DONE -> a second operation is accepted with no idle cycle; two done pulses are spaced 5 cycles apart (edge to edge).
